// File: rtl/slot_allocator_if.sv
`default_nettype none
// ============================================================================
// Module   : slot_allocator_if
// Brief    : Allocation offer / release handshake bundle for slot_allocator.
// Revision : 1.0 - initial release
// ============================================================================
interface slot_allocator_if #(
    parameter int SLOT_COUNT  = 8,
    parameter int INDEX_WIDTH = 3
);
    logic                   alloc_valid;
    logic                   alloc_ready;
    logic [INDEX_WIDTH-1:0] alloc_index;
    logic [SLOT_COUNT-1:0]  alloc_onehot;
    logic                   free_valid;
    logic                   free_ready;
    logic [INDEX_WIDTH-1:0] free_index;

    // master is the allocator itself; slave is the consumer of slots
    modport master (
        output alloc_valid,
        output alloc_index,
        output alloc_onehot,
        output free_ready,
        input  alloc_ready,
        input  free_valid,
        input  free_index
    );

    modport slave (
        input  alloc_valid,
        input  alloc_index,
        input  alloc_onehot,
        input  free_ready,
        output alloc_ready,
        output free_valid,
        output free_index
    );
endinterface
`default_nettype wire

// File: rtl/slot_allocator.sv
`default_nettype none
// ============================================================================
// Module   : slot_allocator
// Brief    : Lowest-free-first slot allocator with checked releases.
// Revision : 1.0 - initial release
// ============================================================================
module slot_allocator #(
    parameter int SLOT_COUNT  = 8,
    parameter int INDEX_WIDTH = 3
) (
    input  logic                   clock,
    input  logic                   clear_n,
    slot_allocator_if.master       bus,
    output logic [SLOT_COUNT-1:0]  used_bitmap,
    output logic [INDEX_WIDTH:0]   used_count,
    output logic                   full,
    output logic                   empty,
    output logic                   free_error
);

    localparam logic [INDEX_WIDTH:0]  C_SLOT_COUNT = (INDEX_WIDTH+1)'(SLOT_COUNT);
    localparam logic [SLOT_COUNT-1:0] C_MAP_ONE    = {{(SLOT_COUNT-1){1'b0}}, 1'b1};

    logic [SLOT_COUNT-1:0]  r_used;
    logic [INDEX_WIDTH:0]   r_count;
    logic                   r_full;
    logic                   r_empty;
    logic                   r_free_error;

    logic [SLOT_COUNT-1:0]  w_used_inc;
    logic [SLOT_COUNT-1:0]  w_offer;
    logic [INDEX_WIDTH-1:0] w_offer_index;
    logic [SLOT_COUNT-1:0]  w_free_mask;
    logic                   w_alloc_valid;
    logic                   w_free_ready;
    logic                   w_alloc_fire;
    logic                   w_free_fire;
    logic                   w_free_hit;
    logic                   w_free_ok;
    logic                   w_free_bad;
    logic [SLOT_COUNT-1:0]  w_used_next;
    logic [INDEX_WIDTH:0]   w_count_next;

    // Adding one ripples through the trailing ones and lands on the lowest
    // zero; XOR with the old map isolates that single bit (zero when full).
    assign w_used_inc = r_used + C_MAP_ONE;
    assign w_offer    = (r_used | w_used_inc) ^ r_used;

    always_comb begin
        w_offer_index = '0;
        for (int i = 0; i < SLOT_COUNT; i++) begin
            if (w_offer[i]) begin
                w_offer_index = w_offer_index | INDEX_WIDTH'(i);
            end
        end
    end

    // Out-of-range indices decode to an all-zero mask and so never hit.
    for (genvar g = 0; g < SLOT_COUNT; g++) begin : g_free_dec
        assign w_free_mask[g] = (bus.free_index == INDEX_WIDTH'(g));
    end

    assign w_alloc_valid = clear_n & ~r_full;
    assign w_free_ready  = clear_n;

    assign w_alloc_fire  = w_alloc_valid & bus.alloc_ready;
    assign w_free_fire   = bus.free_valid & w_free_ready;
    assign w_free_hit    = |(w_free_mask & r_used);
    assign w_free_ok     = w_free_fire & w_free_hit;
    assign w_free_bad    = w_free_fire & ~w_free_hit;

    // The offered slot is never set in r_used, so a same-cycle release of it
    // misses and the two updates can never touch the same bit.
    assign w_used_next  = (r_used | (w_alloc_fire ? w_offer : '0))
                        & ~(w_free_ok ? w_free_mask : '0);
    assign w_count_next = r_count
                        + {{INDEX_WIDTH{1'b0}}, w_alloc_fire}
                        - {{INDEX_WIDTH{1'b0}}, w_free_ok};

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_used       <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_free_error <= 1'b0;
        end else begin
            r_used       <= w_used_next;
            r_count      <= w_count_next;
            r_full       <= (w_count_next == C_SLOT_COUNT);
            r_empty      <= (w_count_next == '0);
            r_free_error <= w_free_bad;
        end
    end

    assign bus.alloc_valid  = w_alloc_valid;
    assign bus.alloc_index  = w_offer_index;
    assign bus.alloc_onehot = w_offer;
    assign bus.free_ready   = w_free_ready;

    assign used_bitmap = r_used;
    assign used_count  = r_count;
    assign full        = r_full;
    assign empty       = r_empty;
    assign free_error  = r_free_error;

endmodule
`default_nettype wire

// File: tb/tb_slot_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_slot_allocator
// Brief    : Directed vector table, reset corner and reference-model traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slot_allocator;

    localparam int SC = 8;
    localparam int IW = 4;

    typedef struct packed {
        logic       ar;
        logic       fv;
        logic [3:0] fi;
        logic [7:0] map;
        logic [4:0] cnt;
        logic [3:0] idx;
        logic       err;
    } vec_t;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic [7:0]  used_bitmap;
    logic [4:0]  used_count;
    logic        full;
    logic        empty;
    logic        free_error;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    slot_allocator_if #(.SLOT_COUNT(SC), .INDEX_WIDTH(IW)) bus ();

    slot_allocator #(.SLOT_COUNT(SC), .INDEX_WIDTH(IW)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .bus         (bus),
        .used_bitmap (used_bitmap),
        .used_count  (used_count),
        .full        (full),
        .empty       (empty),
        .free_error  (free_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic add(input logic ar, input logic fv, input int fi,
                       input int map, input int cnt, input int idx, input logic err);
        vec_t v;
        v.ar = ar; v.fv = fv; v.fi = 4'(fi);
        v.map = 8'(map); v.cnt = 5'(cnt); v.idx = 4'(idx); v.err = err;
        vecs.push_back(v);
    endtask

    // Full observable state against an expected map/count/offer/error.
    task automatic check_state(input string tag, input logic [7:0] map, input int cnt,
                               input int idx, input logic err);
        logic [7:0] one;
        logic       vld;
        one = 8'd1;
        vld = (cnt != SC);
        check({tag, "_map"},    32'(used_bitmap), 32'(map));
        check({tag, "_cnt"},    32'(used_count), 32'(cnt));
        check({tag, "_flags"},  {28'd0, bus.alloc_valid, full, empty, free_error},
                                {28'd0, vld, 1'(cnt == SC), 1'(cnt == 0), err});
        check({tag, "_idx"},    32'(bus.alloc_index), 32'(idx));
        check({tag, "_onehot"}, 32'(bus.alloc_onehot), vld ? 32'(one << idx) : 32'd0);
        check({tag, "_frdy"},   32'(bus.free_ready), 32'd1);
    endtask

    function automatic int lowest_free(input logic [7:0] m);
        for (int i = 0; i < SC; i++) if (!m[i]) return i;
        return -1;
    endfunction

    function automatic int popcount(input logic [7:0] m);
        int c = 0;
        for (int i = 0; i < SC; i++) c += int'(m[i]);
        return c;
    endfunction

    initial begin
        logic [7:0] ref_map;
        logic [7:0] nxt_map;
        logic       exp_err;
        logic       legal;
        int         lf;

        // Fill seven allocations, then one more that fills the table.
        for (int k = 0; k < SC; k++) add(1, 0, 0, (1 << (k + 1)) - 1, k + 1, (k == SC - 1) ? 0 : k + 1, 0);
        add(1, 0, 0, 'hFF, 8, 0, 0);   // ready while full is ignored
        add(0, 1, 5, 'hDF, 7, 5, 0);
        add(1, 1, 5, 'hFF, 8, 0, 1);   // release of the offered slot: alloc wins, error
        add(0, 0, 0, 'hFF, 8, 0, 0);
        add(0, 1, 7, 'h7F, 7, 7, 0);
        add(0, 1, 6, 'h3F, 6, 6, 0);
        add(0, 1, 5, 'h1F, 5, 5, 0);
        add(0, 1, 4, 'h0F, 4, 4, 0);
        add(1, 1, 1, 'h1D, 4, 1, 0);   // simultaneous alloc slot 4 / release slot 1
        add(0, 1, 4, 'h0D, 3, 1, 0);
        add(0, 1, 3, 'h05, 2, 1, 0);
        add(0, 1, 2, 'h01, 1, 1, 0);
        add(1, 0, 0, 'h03, 2, 2, 0);
        add(0, 1, 6, 'h03, 2, 2, 1);
        add(0, 0, 0, 'h03, 2, 2, 0);
        add(0, 1, 9, 'h03, 2, 2, 1);   // out-of-range index
        add(0, 0, 0, 'h03, 2, 2, 0);
        add(0, 1, 0, 'h02, 1, 0, 0);
        add(1, 1, 1, 'h01, 1, 1, 0);
        add(0, 1, 0, 'h00, 0, 0, 0);
        add(0, 1, 0, 'h00, 0, 0, 1);   // release while empty

        bus.alloc_ready = 1'b0;
        bus.free_valid  = 1'b0;
        bus.free_index  = '0;

        #12;
        check("rst_map",   32'(used_bitmap), 32'd0);
        check("rst_cnt",   32'(used_count), 32'd0);
        check("rst_flags", {28'd0, bus.alloc_valid, full, empty, free_error}, 32'b0010);
        check("rst_frdy",  32'(bus.free_ready), 32'd0);

        @(negedge clock);
        clear_n = 1'b1;
        #1;
        check_state("post_rst", 8'h00, 0, 0, 1'b0);

        @(posedge clock); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            bus.alloc_ready = vecs[i].ar;
            bus.free_valid  = vecs[i].fv;
            bus.free_index  = vecs[i].fi;
            @(posedge clock); #1;
            check_state($sformatf("v%0d", i), vecs[i].map, int'(vecs[i].cnt),
                        int'(vecs[i].idx), vecs[i].err);
        end

        // Build map 0x07, then assert reset mid-cycle with the handshake live.
        bus.free_valid  = 1'b0;
        bus.alloc_ready = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        check("pre_clr_map", 32'(used_bitmap), 32'h07);
        #2;
        clear_n = 1'b0;
        #1;
        check("clr_map",   32'(used_bitmap), 32'd0);
        check("clr_cnt",   32'(used_count), 32'd0);
        check("clr_flags", {28'd0, bus.alloc_valid, full, empty, free_error}, 32'b0010);
        check("clr_frdy",  32'(bus.free_ready), 32'd0);
        @(posedge clock); #1;
        check("clr_hold_map", 32'(used_bitmap), 32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        #1;
        check_state("clr_rel", 8'h00, 0, 0, 1'b0);
        bus.alloc_ready = 1'b0;
        @(posedge clock); #1;
        check("clr_idle_map", 32'(used_bitmap), 32'd0);

        ref_map = 8'h00;
        exp_err = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            lf = lowest_free(ref_map);
            check("rnd_map", 32'(used_bitmap), 32'(ref_map));
            check("rnd_cnt", 32'(used_count), 32'(popcount(ref_map)));
            check("rnd_offer", {bus.alloc_valid, 27'd0, bus.alloc_index},
                  (lf < 0) ? 32'd0 : {1'b1, 27'd0, 4'(lf)});
            check("rnd_err", 32'(free_error), 32'(exp_err));

            bus.alloc_ready = 1'($urandom_range(0, 1));
            bus.free_valid  = 1'($urandom_range(0, 1));
            bus.free_index  = 4'($urandom_range(0, 9));

            nxt_map = ref_map;
            if (lf >= 0 && bus.alloc_ready) nxt_map[lf] = 1'b1;
            legal = bus.free_valid && (bus.free_index < 4'd8) && ref_map[bus.free_index[2:0]];
            if (legal) nxt_map[bus.free_index[2:0]] = 1'b0;
            exp_err = bus.free_valid && !legal;
            ref_map = nxt_map;
            @(posedge clock); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slot_allocator.md
SLOT_ALLOCATOR -- requirements
Module: slot_allocator

Interface
REQ-001 SHALL have parameter SLOT_COUNT, default 8, number of allocatable slots (>=2).
REQ-002 SHALL have parameter INDEX_WIDTH, default 3, width of a slot index (2**INDEX_WIDTH >= SLOT_COUNT).
REQ-003 SHALL have one clock and an asynchronous active-low reset; ports are named clock and clear_n.
REQ-004 SHALL have port: clock  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port: clear_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: alloc_valid  output  1  a free slot is offered.
REQ-007 SHALL have port: alloc_ready  input  1  consumer accepts the offered slot.
REQ-008 SHALL have port: alloc_index  output  INDEX_WIDTH  binary index of the offered slot.
REQ-009 SHALL have port: alloc_onehot  output  SLOT_COUNT  one-hot mask of the offered slot.
REQ-010 SHALL have port: free_valid  input  1  a slot release is presented.
REQ-011 SHALL have port: free_ready  output  1  release accepted (constant 1 outside reset).
REQ-012 SHALL have port: free_index  input  INDEX_WIDTH  index of the slot to release.
REQ-013 SHALL have port: used_bitmap  output  SLOT_COUNT  registered in-use map, bit i = slot i allocated.
REQ-014 SHALL have port: used_count  output  INDEX_WIDTH+1  registered number of allocated slots.
REQ-015 SHALL have port: full  output  1  all slots allocated (registered).
REQ-016 SHALL have port: empty  output  1  no slots allocated (registered).
REQ-017 SHALL have port: free_error  output  1  one-cycle registered pulse on an illegal release.

Function
REQ-018 SHALL offer the lowest-numbered free slot: next map = used_bitmap | (used_bitmap + 1), alloc_onehot = next map XOR used_bitmap, computed in SLOT_COUNT-bit arithmetic.
REQ-019 SHALL drive alloc_valid = ~full while clear_n is high; alloc_index and alloc_onehot are valid only while alloc_valid is 1, zero when full.
REQ-020 SHALL complete an allocation on a rising edge with alloc_valid & alloc_ready: set the offered bit, increment used_count; the new state is visible the next cycle (latency 1).
REQ-021 SHALL complete a release on a rising edge with free_valid & free_ready when free_index < SLOT_COUNT and that bit is set: clear the bit, decrement used_count; latency 1.
REQ-022 SHALL treat a release of an unallocated slot, or free_index >= SLOT_COUNT, as illegal: no state change, free_error = 1 for the following cycle only.
REQ-023 SHALL apply a simultaneous legal allocation and release in the same cycle together: both bits updated, used_count unchanged.
REQ-024 SHALL treat a release naming the slot offered in the same cycle as illegal (that slot is free), while the allocation itself completes.
REQ-025 SHALL not re-offer a slot released in cycle N before cycle N+1.
REQ-026 SHALL keep full = (used_count == SLOT_COUNT), empty = (used_count == 0), and used_count = popcount(used_bitmap) at all times.
REQ-027 SHALL ignore alloc_ready while alloc_valid is 0 (no wrap of used_bitmap to zero when full).

Reset
REQ-028 SHALL, while clear_n is low, asynchronously force used_bitmap = 0, used_count = 0, full = 0, empty = 1, free_error = 0, alloc_valid = 0, free_ready = 0.
REQ-029 SHALL, on the first cycle after clear_n rises, present alloc_valid = 1, alloc_index = 0, alloc_onehot = 1.
REQ-030 SHALL discard any allocation or release in progress when clear_n asserts mid-operation; no partial state survives.

Verification
REQ-031 SHALL cover: reset, then alloc_ready held high for 8 cycles (SLOT_COUNT 8) -> indices 0..7 in order, then full = 1, alloc_valid = 0, used_bitmap = 0xFF.
REQ-032 SHALL cover: map 0xFF, release index 5 -> next cycle used_bitmap = 0xDF, alloc_index = 5, used_count = 7, full = 0.
REQ-033 SHALL cover: map 0x0F, same-cycle allocate (slot 4) and release index 1 -> used_bitmap = 0x1D, used_count = 4.
REQ-034 SHALL cover: map 0x03, release index 6 -> free_error pulses one cycle, used_bitmap stays 0x03; then release index 9 (INDEX_WIDTH 4, SLOT_COUNT 8) -> free_error pulses again.
REQ-035 SHALL cover: map 0x07, clear_n pulsed low mid-cycle with alloc handshake active -> outputs reset immediately, used_bitmap = 0, alloc_index = 0 after release.
REQ-036 SHALL cover: randomized alloc/free traffic for 10000 cycles against a reference bitmap -> no duplicate allocation, offered index always lowest free, used_count matches popcount.
